// File: rtl/tl_log_buffer.sv
// TileLink log capture buffer: per-channel capture registers, round-robin merge into a record FIFO.
// Define TL_LOG_DROP_CNT_EN to build the saturating drop counter and sticky overflow flag.
module tl_log_buffer #(
    parameter int NUM_CH = 5,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 256
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          en,
    input  logic [NUM_CH*ADDR_W-1:0]   in_address,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    input  logic [NUM_CH*8-1:0]        in_opcode,
    input  logic [NUM_CH*8-1:0]        in_param,
    input  logic [NUM_CH*8-1:0]        in_source,
    input  logic [NUM_CH*8-1:0]        in_sink,
    input  logic [63:0]                stamp,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_channel,
    output logic [7:0]                 out_opcode,
    output logic [7:0]                 out_param,
    output logic [7:0]                 out_source,
    output logic [7:0]                 out_sink,
    output logic [ADDR_W-1:0]          out_address,
    output logic [DATA_W-1:0]          out_data,
    output logic [63:0]                out_stamp,
    output logic [$clog2(DEPTH):0]     out_level,
    output logic [15:0]                drop_cnt,
    output logic                       overflow
);

    localparam int AW             = $clog2(DEPTH);
    localparam int LVL_W          = AW + 1;
    localparam int PTR_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CAP_W          = 32 + ADDR_W + DATA_W + 64;
    localparam int REC_W          = 8 + CAP_W;
    localparam int unsigned NCH   = NUM_CH;

    logic [NUM_CH-1:0] cap_full;
    logic [NUM_CH-1:0] gnt_vec;
    logic [NUM_CH-1:0] load;
    logic [CAP_W-1:0]  cap_rec [NUM_CH];
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  gnt_idx;
    logic [PTR_W-1:0]  cand;
    int unsigned       sum;
    logic              grant;
    logic              fifo_full;
    logic              pop;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [REC_W-1:0]  mem [DEPTH];

    // Full uses registered occupancy, so a same-cycle pop never opens a slot for this grant.
    assign fifo_full = (level == LVL_W'(DEPTH));
    assign out_valid = (level != '0);
    assign out_level = level;
    assign pop       = out_valid && out_ready;

    always_comb begin
        grant   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        sum     = 0;
        if (!fifo_full) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                sum = 32'(rr_ptr) + k;
                if (sum >= NCH) sum = sum - NCH;
                cand = PTR_W'(sum);
                if (!grant && cap_full[cand]) begin
                    grant   = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        gnt_vec = '0;
        if (grant) gnt_vec[gnt_idx] = 1'b1;
        // A granted capture empties this edge, so a new strobe can refill it without loss.
        load = en & (~cap_full | gnt_vec);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cap_full <= '0;
            rr_ptr   <= '0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (load[i])         cap_full[i] <= 1'b1;
                else if (gnt_vec[i]) cap_full[i] <= 1'b0;
            end
            if (grant) rr_ptr <= (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < NCH; i++) begin
            if (load[i]) begin
                cap_rec[i] <= {in_opcode[i*8 +: 8], in_param[i*8 +: 8],
                               in_source[i*8 +: 8], in_sink[i*8 +: 8],
                               in_address[i*ADDR_W +: ADDR_W],
                               in_data[i*DATA_W +: DATA_W], stamp};
            end
        end
        if (grant) mem[wr_ptr] <= {8'(gnt_idx), cap_rec[gnt_idx]};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (grant) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({grant, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    assign {out_channel, out_opcode, out_param, out_source, out_sink,
            out_address, out_data, out_stamp} = mem[rd_ptr];

`ifdef TL_LOG_DROP_CNT_EN
    logic [NUM_CH-1:0] drop;
    logic [16:0]       drop_sum;

    always_comb begin
        drop     = en & cap_full & ~gnt_vec;
        drop_sum = {1'b0, drop_cnt};
        for (int unsigned i = 0; i < NCH; i++) begin
            drop_sum = drop_sum + 17'(drop[i]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            drop_cnt <= drop_sum[16] ? '1 : drop_sum[15:0];
            if (|drop) overflow <= 1'b1;
        end
    end
`else
    assign drop_cnt = '0;
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_tl_log_buffer.sv
// Scoreboard bench for tl_log_buffer: expected records queued at stimulus time, compared on pop.
module tb_tl_log_buffer;

    localparam int NUM_CH = 5;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 256;
`ifdef TL_LOG_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic                     clock;
    logic                     reset;
    logic [NUM_CH-1:0]        en;
    logic [NUM_CH*ADDR_W-1:0] in_address;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH*8-1:0]      in_opcode, in_param, in_source, in_sink;
    logic [63:0]              stamp;
    logic                     out_valid;
    logic                     out_ready;
    logic [7:0]               out_channel, out_opcode, out_param, out_source, out_sink;
    logic [ADDR_W-1:0]        out_address;
    logic [DATA_W-1:0]        out_data;
    logic [63:0]              out_stamp;
    logic [$clog2(DEPTH):0]   out_level;
    logic [15:0]              drop_cnt;
    logic                     overflow;

    tl_log_buffer #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset(reset), .en(en),
        .in_address(in_address), .in_data(in_data),
        .in_opcode(in_opcode), .in_param(in_param), .in_source(in_source), .in_sink(in_sink),
        .stamp(stamp), .out_valid(out_valid), .out_ready(out_ready),
        .out_channel(out_channel), .out_opcode(out_opcode), .out_param(out_param),
        .out_source(out_source), .out_sink(out_sink), .out_address(out_address),
        .out_data(out_data), .out_stamp(out_stamp), .out_level(out_level),
        .drop_cnt(drop_cnt), .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]   ch;
        logic [63:0]  addr;
        logic [255:0] data;
        logic [31:0]  flds;
        logic [63:0]  st;
    } rec_t;

    rec_t        exp_q[$];
    int unsigned pop_log[$];
    int unsigned cyc;
    int          tests_run;
    int          tests_failed;
    rec_t        mon_r;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        stamp = stamp + 64'd1;
        cyc++;
    endtask

    function automatic rec_t make_rec(input int unsigned ch, input int unsigned n,
                                      input logic [63:0] st);
        rec_t r;
        r.ch   = 8'(ch);
        r.addr = 64'h1000 + 64'(n) * 64'h100;
        r.data = {32'(n), 32'(ch), 192'h5a5a_0000_c3c3_ffff_1234_5678_9abc_def0_0f0f_f0f0_aaaa_5555};
        r.flds = {8'(4 + n), 8'(ch), 8'(n), ~8'(n)};
        r.st   = st;
        return r;
    endfunction

    task automatic stage(input int unsigned ch, input int unsigned n, output rec_t r);
        r = make_rec(ch, n, stamp);
        in_address[ch*ADDR_W +: ADDR_W] = r.addr;
        in_data[ch*DATA_W +: DATA_W]    = r.data;
        {in_opcode[ch*8 +: 8], in_param[ch*8 +: 8], in_source[ch*8 +: 8], in_sink[ch*8 +: 8]} = r.flds;
        en[ch] = 1'b1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        en        = '0;
        out_ready = 1'b0;
        tick();
        tick();
        exp_q.delete();
        pop_log.delete();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int unsigned budget);
        int unsigned k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check("drain_timeout", 256'(exp_q.size()), 256'(0));
    endtask

    function automatic int unsigned exp_drops(input int unsigned c);
        int unsigned d;
        if (c == 0)       d = 0;
        else if (c <= 16) d = 4 * c;
        else              d = 64 + 5 * (c - 16);
        if (!DROP_EN) return 0;
        return (d > 65535) ? 65535 : d;
    endfunction

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_pop", 256'(out_valid), 256'(0));
            end else begin
                mon_r = exp_q.pop_front();
                pop_log.push_back(cyc);
                check("out_channel", 256'(out_channel), 256'(mon_r.ch));
                check("out_address", 256'(out_address), 256'(mon_r.addr));
                check("out_data", out_data, mon_r.data);
                check("out_fields", 256'({out_opcode, out_param, out_source, out_sink}), 256'(mon_r.flds));
                check("out_stamp", 256'(out_stamp), 256'(mon_r.st));
            end
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t        r;
        logic [63:0] s0;
        int unsigned span;
        localparam int unsigned SAT_LAST = 13112;

        reset = 1'b1; en = '0; out_ready = 1'b0; stamp = '0; cyc = 0;
        in_address = '0; in_data = '0; in_opcode = '0; in_param = '0; in_source = '0; in_sink = '0;
        tests_run = 0; tests_failed = 0;

        do_reset();
        check("rst_valid", 256'(out_valid), 256'(0));
        check("rst_level", 256'(out_level), 256'(0));
        check("rst_drop", 256'(drop_cnt), 256'(0));
        check("rst_ovf", 256'(overflow), 256'(0));

        // Single record on channel 2, two-cycle latency
        stamp = 64'd10;
        stage(2, 0, r);
        exp_q.push_back(r);
        out_ready = 1'b1;
        tick();
        en = '0;
        check("single_e0_valid", 256'(out_valid), 256'(0));
        tick();
        check("single_e1_valid", 256'(out_valid), 256'(1));
        check("single_level1", 256'(out_level), 256'(1));
        tick();
        check("single_level0", 256'(out_level), 256'(0));
        wait_drain(10);

        // All channels at once: channel order, back to back
        do_reset();
        out_ready = 1'b1;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            stage(ch, ch + 1, r);
            exp_q.push_back(r);
        end
        tick();
        en = '0;
        wait_drain(20);
        check("rr_pop_count", 256'(pop_log.size()), 256'(5));
        span = (pop_log.size() >= 5) ? pop_log[4] - pop_log[0] : 0;
        check("rr_back_to_back", 256'(span), 256'(4));
        // rr_ptr back at 0: channel 0 wins over channel 4
        stage(4, 9, r);
        stage(0, 8, r);
        exp_q.push_back(make_rec(0, 8, stamp));
        exp_q.push_back(make_rec(4, 9, stamp));
        tick();
        en = '0;
        wait_drain(20);

        // Fairness: channels 0 and 3 strobe every cycle
        do_reset();
        out_ready = 1'b1;
        s0 = stamp;
        exp_q.push_back(make_rec(0, 0, s0));
        exp_q.push_back(make_rec(3, 0, s0));
        exp_q.push_back(make_rec(0, 1, s0 + 64'd1));
        exp_q.push_back(make_rec(3, 2, s0 + 64'd2));
        exp_q.push_back(make_rec(0, 3, s0 + 64'd3));
        exp_q.push_back(make_rec(3, 4, s0 + 64'd4));
        exp_q.push_back(make_rec(0, 5, s0 + 64'd5));
        for (int unsigned c = 0; c < 6; c++) begin
            stage(0, c, r);
            stage(3, c, r);
            tick();
            check("fair_drop", 256'(drop_cnt), 256'(DROP_EN ? c : 0));
        end
        en = '0;
        wait_drain(20);
        check("fair_ovf", 256'(overflow), 256'(DROP_EN));

        // Full FIFO: 16 queued, 17th held in capture, 18th dropped
        do_reset();
        for (int unsigned n = 0; n < 17; n++) begin
            stage(n % 5, n, r);
            exp_q.push_back(r);
            tick();
            en = '0;
        end
        stage(1, 17, r);
        tick();
        en = '0;
        check("full_level", 256'(out_level), 256'(16));
        check("full_drop", 256'(drop_cnt), 256'(DROP_EN ? 1 : 0));
        check("full_ovf", 256'(overflow), 256'(DROP_EN));
        tick(); tick(); tick();
        check("full_hold_level", 256'(out_level), 256'(16));
        check("full_hold_addr", 256'(out_address), 256'(64'h1000));
        out_ready = 1'b1;
        wait_drain(60);
        check("full_drain_count", 256'(pop_log.size()), 256'(17));
        check("full_drained_level", 256'(out_level), 256'(0));

        // Saturation: every channel strobes every cycle with no consumer
        do_reset();
        for (int unsigned ch = 0; ch < NUM_CH; ch++) stage(ch, 20 + ch, r);
        for (int unsigned c = 0; c <= SAT_LAST; c++) begin
            tick();
            if (c <= 20 || c == SAT_LAST) check("sat_drop", 256'(drop_cnt), 256'(exp_drops(c)));
        end
        en = '0;
        check("sat_ovf", 256'(overflow), 256'(DROP_EN));

        // Async reset in the middle of a drain
        do_reset();
        s0 = stamp;
        exp_q.push_back(make_rec(0, 0, s0));
        exp_q.push_back(make_rec(3, 0, s0));
        exp_q.push_back(make_rec(0, 1, s0 + 64'd1));
        for (int unsigned c = 0; c < 2; c++) begin
            stage(0, c, r);
            stage(3, c, r);
            tick();
        end
        en = '0;
        tick(); tick(); tick();
        check("ar_pre_level", 256'(out_level), 256'(3));
        check("ar_pre_drop", 256'(drop_cnt), 256'(DROP_EN ? 1 : 0));
        out_ready = 1'b1;
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", 256'(out_valid), 256'(0));
        check("ar_level", 256'(out_level), 256'(0));
        check("ar_drop", 256'(drop_cnt), 256'(0));
        exp_q.delete();
        #2;
        reset = 1'b0;
        stage(2, 7, r);
        exp_q.push_back(r);
        tick();
        en = '0;
        check("ar_lat_e0", 256'(out_valid), 256'(0));
        tick();
        check("ar_lat_e1", 256'(out_valid), 256'(1));
        wait_drain(10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
